// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and default sizing for the round-robin resource arbiter
package arb_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, WAIT, RELEASE} arb_state_e;
    localparam int N_REQ_DEF = 4;
    localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner select (rotate, lowest-set pick, rotate back)
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IW-1:0]    idx,
    output logic             any
);
    logic [N_REQ-1:0] rot, pick;
    always_comb begin
        rot = N_REQ'({req, req} >> ptr);
        pick = rot & (~rot + 1'b1);
        onehot = N_REQ'({pick, pick} >> (N_REQ - int'(ptr)));
        any = |req;
        idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (onehot[i]) idx = IW'(i);
    end
endmodule

// File: rtl/rr_resource_arb.sv
// rr_resource_arb: round-robin sequencer granting one requester the shared resource with a watchdog
module rr_resource_arb
    import arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W = 32
) (
    input  logic             clk_top,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             res_start,
    input  logic             res_done,
    output logic             timeout_err,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);
    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT);
    arb_state_e state, nxt;
    logic [N_REQ-1:0] pick_oh;
    logic [IW-1:0] pick_idx, ptr, win;
    logic any, to_flag, expired;
    logic [TW-1:0] timer;

    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req(req), .ptr(ptr), .onehot(pick_oh), .idx(pick_idx), .any(any)
    );

    assign expired = timer == TW'(TIMEOUT - 1);

    always_ff @(posedge clk_top)
        state <= !reset_n ? IDLE : nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = any ? GRANT : IDLE;
            GRANT:   nxt = res_done ? RELEASE : WAIT;
            WAIT:    nxt = (res_done || expired) ? RELEASE : WAIT;
            RELEASE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        res_start = state == GRANT;
        busy = state != IDLE;
        timeout_err = state == RELEASE && to_flag;
    end

    always_ff @(posedge clk_top) begin
        if (!reset_n) begin
            grant <= '0;
            win <= '0;
            ptr <= '0;
            timer <= '0;
            to_flag <= 1'b0;
            done_cnt <= '0;
        end else begin
            if (state == IDLE && any) begin
                grant <= pick_oh;
                win <= pick_idx;
            end else if (nxt == RELEASE) begin
                grant <= '0;
            end
            timer <= state == WAIT ? timer + 1'b1 : '0;
            // done takes precedence over an expiring watchdog in the same cycle
            to_flag <= state == WAIT && !res_done && expired;
            if ((state == GRANT || state == WAIT) && res_done && done_cnt != '1)
                done_cnt <= done_cnt + 1'b1;
            if (state == RELEASE)
                ptr <= win == IW'(N_REQ - 1) ? '0 : win + 1'b1;
        end
    end

    a_grant_onehot: assert property (@(posedge clk_top) disable iff (!reset_n) $onehot0(grant));
    a_start_state:  assert property (@(posedge clk_top) disable iff (!reset_n) res_start |-> state == GRANT);
    a_grant_busy:   assert property (@(posedge clk_top) disable iff (!reset_n) (grant != '0) |-> busy);
endmodule

// File: tb/tb_rr_resource_arb.sv
// tb_rr_resource_arb: directed self-checking bench for rr_resource_arb
module tb_rr_resource_arb;
    logic clk_top = 1'b0;
    logic reset_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] grant;
    logic res_start, res_done = 1'b0, timeout_err, busy;
    logic [31:0] done_cnt;
    int n_cmp = 0, n_err = 0, cyc = 0;

    rr_resource_arb #(.N_REQ(4), .TIMEOUT(16), .CNT_W(32)) dut (
        .clk_top(clk_top), .reset_n(reset_n), .req(req), .grant(grant),
        .res_start(res_start), .res_done(res_done), .timeout_err(timeout_err),
        .busy(busy), .done_cnt(done_cnt)
    );

    always #5 clk_top = ~clk_top;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_top);
        #1;
        cyc++;
    endtask

    task automatic wait_start();
        int n = 0;
        while (res_start !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("start_seen", 32'(res_start), 1);
    endtask

    logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        int last, w;
        step();
        step();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(res_start), 0);
        chk("rst_cnt", done_cnt, 0);
        reset_n = 1'b1;
        step();
        // single request, done on second WAIT cycle
        req = 4'b0001;
        step();
        chk("t1_grant", 32'(grant), 32'b0001);
        chk("t1_start", 32'(res_start), 1);
        req = '0;
        step();
        chk("t1_wait_start", 32'(res_start), 0);
        chk("t1_wait_grant", 32'(grant), 32'b0001);
        step();
        res_done = 1'b1;
        step();
        res_done = 1'b0;
        chk("t1_rel_grant", 32'(grant), 0);
        chk("t1_cnt", done_cnt, 1);
        chk("t1_rel_to", 32'(timeout_err), 0);
        step();
        chk("t1_idle_busy", 32'(busy), 0);
        // round robin with all requesting
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        req = 4'b1111;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            wait_start();
            chk($sformatf("rr_grant%0d", k), 32'(grant), 32'(rr_exp[k]));
            if (k > 0) chk($sformatf("rr_gap%0d", k), cyc - last, 5);
            last = cyc;
            if (k == 4) req = '0;
            step();
            step();
            res_done = 1'b1;
            step();
            res_done = 1'b0;
            chk($sformatf("rr_rel%0d", k), 32'(grant), 0);
            chk($sformatf("rr_cnt%0d", k), done_cnt, k + 1);
        end
        // watchdog timeout
        req = 4'b0100;
        wait_start();
        chk("to_grant", 32'(grant), 32'b0100);
        req = '0;
        step();
        w = 0;
        while (grant == 4'b0100 && w < 40) begin
            w++;
            step();
        end
        chk("to_wait_cycles", w, 16);
        chk("to_err", 32'(timeout_err), 1);
        chk("to_cnt", done_cnt, 5);
        step();
        chk("to_err_clear", 32'(timeout_err), 0);
        chk("to_idle", 32'(busy), 0);
        // zero-latency resource
        req = 4'b1000;
        wait_start();
        chk("zl_grant", 32'(grant), 32'b1000);
        res_done = 1'b1;
        req = '0;
        step();
        res_done = 1'b0;
        chk("zl_rel_grant", 32'(grant), 0);
        chk("zl_cnt", done_cnt, 6);
        chk("zl_to", 32'(timeout_err), 0);
        step();
        // reset mid-WAIT
        req = 4'b0010;
        wait_start();
        chk("mr_grant", 32'(grant), 32'b0010);
        req = '0;
        step();
        chk("mr_wait_grant", 32'(grant), 32'b0010);
        reset_n = 1'b0;
        step();
        chk("mr_grant0", 32'(grant), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_cnt", done_cnt, 0);
        reset_n = 1'b1;
        req = 4'b0011;
        step();
        chk("mr_regrant", 32'(grant), 32'b0001);
        req = '0;
        step();
        res_done = 1'b1;
        step();
        res_done = 1'b0;
        chk("mr_cnt1", done_cnt, 1);
        step();
        // done on the exact timeout cycle
        req = 4'b0100;
        wait_start();
        req = '0;
        repeat (16) step();
        chk("dt_last_wait", 32'(grant), 32'b0100);
        res_done = 1'b1;
        step();
        res_done = 1'b0;
        chk("dt_to", 32'(timeout_err), 0);
        chk("dt_cnt", done_cnt, 2);
        chk("dt_grant", 32'(grant), 0);
        step();
        // done while idle is ignored
        res_done = 1'b1;
        step();
        step();
        res_done = 1'b0;
        chk("idle_done_cnt", done_cnt, 2);
        chk("idle_done_busy", 32'(busy), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
